// File: rtl/regfile_pkg.sv
// Shared types and defaults for the MIPS-lite register file.
// Imported by regfile_scoreboard and regfile_sb.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef logic [DATA_W_DEF-1:0] reg_data_t;
    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: busy vector, reservation accept,
// flush and registered busy count for the register file.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [ADDR_W-1:0]      wr_addr,
    input  logic                   rsv_en,
    input  logic [ADDR_W-1:0]      rsv_addr,
    input  logic                   flush,
    output logic                   rsv_ok,
    output logic [(2**ADDR_W)-1:0] busy,
    output logic [ADDR_W:0]        busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_nxt;
    logic [ADDR_W:0]  cnt_nxt;
    logic             wr_hit;

    assign wr_hit = wr_en && (wr_addr == rsv_addr);
    assign rsv_ok = rsv_en && (!busy[rsv_addr] || wr_hit) && !flush;

    // Next busy vector: retire, then reserve; flush wins over both.
    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wr_en)
                busy_nxt[wr_addr] = 1'b0;
            if (rsv_ok)
                busy_nxt[rsv_addr] = 1'b1;
        end
        if (ZERO_REG != 0)
            busy_nxt[REG_ZERO] = 1'b0;
    end

    // Popcount of the next vector so the registered count tracks busy.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end

    // Busy state and its count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NUM_RD async read ports, one write-back port
// and pending-write scoreboard. Optional: REGFILE_BYPASS_EN.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     rsv_ok,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_keep;

    assign wr_keep = wr_en &&
        !((ZERO_REG != 0) && (wr_addr == ADDR_W'(REG_ZERO)));

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .rsv_ok   (rsv_ok),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    // Data array; writes to a hardwired zero register are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (wr_keep) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              hz;
        logic [DATA_W-1:0] d;
        logic              b;

        assign addr = rd_addr[g*ADDR_W +: ADDR_W];
        assign hz   = (ZERO_REG != 0) &&
                      (addr == ADDR_W'(REG_ZERO));

        // Read mux with optional same-cycle write-back forwarding.
        always_comb begin
            d = hz ? '0 : regs[addr];
            b = hz ? 1'b0 : busy[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (wr_addr == addr) && !hz) begin
                d = wr_data;
                b = 1'b0;
            end
`endif
        end

        assign rd_data[g*DATA_W +: DATA_W] = d;
        assign rd_busy[g] = b;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed cases plus
// randomized traffic against an array/bit-vector reference model.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            rsv_en;
    logic [AW-1:0]   rsv_addr;
    logic            rsv_ok;
    logic            flush;
    logic [AW:0]     busy_cnt;

    int checks = 0;
    int errors = 0;

    reg_data_t m_mem [32];
    logic [31:0] m_busy;

    logic        o_ok;
    reg_data_t   o_d0, o_d1;
    logic [1:0]  o_b;

    always #5 clk = ~clk;

    regfile_sb #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ok   (rsv_ok),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_busy = '0;
    endtask

    function automatic reg_data_t exp_data(input reg_addr_t a);
        reg_data_t v;
        v = (a == REG_ZERO) ? '0 : m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a && a != REG_ZERO) v = wr_data;
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input reg_addr_t a);
        logic v;
        v = (a == REG_ZERO) ? 1'b0 : m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a && a != REG_ZERO) v = 1'b0;
`endif
        return v;
    endfunction

    // One clock: drive, check combinational outputs, clock, check count.
    task automatic step(input logic we, input reg_addr_t wa,
                        input reg_data_t wd, input logic re,
                        input reg_addr_t ra, input logic fl,
                        input reg_addr_t a0, input reg_addr_t a1);
        logic ok;
        reg_addr_t r0, r1;
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra; flush = fl;
        rd_addr = {a1, a0};
        #1;
        r0 = a0;
        r1 = a1;
        ok = re && !fl && (!m_busy[ra] || (we && wa == ra));
        o_ok = rsv_ok;
        o_d0 = rd_data[DW-1:0];
        o_d1 = rd_data[2*DW-1:DW];
        o_b  = rd_busy;
        chk("rsv_ok", 64'(o_ok), 64'(ok));
        chk("rd_data0", 64'(o_d0), 64'(exp_data(r0)));
        chk("rd_data1", 64'(o_d1), 64'(exp_data(r1)));
        chk("rd_busy0", 64'(o_b[0]), 64'(exp_busy(r0)));
        chk("rd_busy1", 64'(o_b[1]), 64'(exp_busy(r1)));
        @(posedge clk);
        #1;
        if (we && wa != REG_ZERO) m_mem[wa] = wd;
        if (fl) begin
            m_busy = '0;
        end else begin
            if (we) m_busy[wa] = 1'b0;
            if (ok && ra != REG_ZERO) m_busy[ra] = 1'b1;
        end
        chk("busy_cnt", 64'(busy_cnt), 64'($countones(m_busy)));
    endtask

    task automatic idle(input reg_addr_t a0, input reg_addr_t a1);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0, a0, a1);
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
        rd_addr = {5'd5, 5'd31};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", 64'(busy_cnt), 64'd0);
        chk("rst_data", 64'(rd_data), 64'd0);
        chk("rst_busy", 64'(rd_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Write/read and zero register
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0, '0);
        idle(5'd5, 5'd0);
        chk("t2_r5", 64'(o_d0), 64'hDEADBEEF);
        step(1'b1, 5'd0, 32'h1234, 1'b0, '0, 1'b0, '0, '0);
        idle(5'd0, 5'd5);
        chk("t2_r0", 64'(o_d0), 64'd0);

        // Reserve, WAW reject, retire
        step(1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 5'd7, '0);
        chk("t3_ok", 64'(o_ok), 64'd1);
        chk("t3_cnt1", 64'(busy_cnt), 64'd1);
        step(1'b0, '0, '0, 1'b1, 5'd7, 1'b0, 5'd7, '0);
        chk("t3_busy", 64'(o_b[0]), 64'd1);
        chk("t3_rej", 64'(o_ok), 64'd0);
        step(1'b1, 5'd7, 32'h55, 1'b0, '0, 1'b0, '0, '0);
        chk("t3_cnt0", 64'(busy_cnt), 64'd0);

        // Same-cycle retire and re-reserve
        step(1'b0, '0, '0, 1'b1, 5'd9, 1'b0, '0, '0);
        step(1'b1, 5'd9, 32'hAA, 1'b1, 5'd9, 1'b0, '0, '0);
        chk("t4_ok", 64'(o_ok), 64'd1);
        idle(5'd9, '0);
        chk("t4_busy", 64'(o_b[0]), 64'd1);
        chk("t4_data", 64'(o_d0), 64'hAA);
        step(1'b1, 5'd9, 32'hAA, 1'b0, '0, 1'b0, '0, '0);

        // Flush with concurrent write
        step(1'b0, '0, '0, 1'b1, 5'd1, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd2, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd3, 1'b0, '0, '0);
        chk("t5_cnt3", 64'(busy_cnt), 64'd3);
        step(1'b1, 5'd4, 32'h10, 1'b1, 5'd8, 1'b1, '0, '0);
        chk("t5_ok", 64'(o_ok), 64'd0);
        chk("t5_cnt0", 64'(busy_cnt), 64'd0);
        idle(5'd4, 5'd1);
        chk("t5_r4", 64'(o_d0), 64'h10);

        // Write-back forwarding to read port 1
        step(1'b0, '0, '0, 1'b1, 5'd6, 1'b0, '0, '0);
        step(1'b1, 5'd6, 32'h77, 1'b0, '0, 1'b0, '0, 5'd6);
`ifdef REGFILE_BYPASS_EN
        chk("t6_d1", 64'(o_d1), 64'h77);
        chk("t6_b1", 64'(o_b[1]), 64'd0);
`else
        chk("t6_d1", 64'(o_d1), 64'd0);
        chk("t6_b1", 64'(o_b[1]), 64'd1);
`endif

        // Randomized traffic over a small address window
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 19) == 0),
                 5'($urandom_range(0, 8)),
                 5'($urandom_range(0, 8)));
        end

        // Asynchronous reset mid-cycle
        step(1'b1, 5'd12, 32'hCAFE, 1'b1, 5'd13, 1'b0, '0, '0);
        @(negedge clk);
        wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
        rd_addr = {5'd13, 5'd12};
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("arst_cnt", 64'(busy_cnt), 64'd0);
        chk("arst_r12", 64'(rd_data[DW-1:0]), 64'd0);
        chk("arst_b13", 64'(rd_busy[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, '0, '0, 1'b1, 5'd13, 1'b0, 5'd12, 5'd13);
        chk("arst_ok", 64'(o_ok), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
